// File: rtl/ov7670_config_sequencer_if.sv
// Bus between the OV7670 config sequencer, its control port, the config ROM and the SCCB master.
// The master modport is the sequencer side.
interface ov7670_config_sequencer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sccb_start;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_value;
  logic        sccb_ready;

  modport master (
    input  start, rom_data, sccb_ready,
    output busy, done, rom_addr, sccb_start, sccb_reg, sccb_value
  );

  modport slave (
    output start, rom_data, sccb_ready,
    input  busy, done, rom_addr, sccb_start, sccb_reg, sccb_value
  );
endinterface

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 config ROM from address 0 and turns each {reg, value} entry into one SCCB write.
// Two special words are recognised: a settle delay and the end-of-table marker.
module ov7670_config_sequencer #(
  parameter int unsigned DELAY_CYCLES = 250_000,
  parameter logic [15:0] END_WORD     = 16'hFFFF,
  parameter logic [15:0] DELAY_WORD   = 16'hFFF0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ov7670_config_sequencer_if.master    bus
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = $clog2(DELAY_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH1, S_FETCH2, S_DECODE, S_ISSUE,
    S_WAIT_SCCB, S_DELAY, S_NEXT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                sccb_start_q, sccb_start_d;
  logic [BYTE_W-1:0]   sccb_reg_q, sccb_reg_d;
  logic [BYTE_W-1:0]   sccb_value_q, sccb_value_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                first_q, first_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= '0;
      sccb_start_q <= 1'b0;
      sccb_reg_q   <= '0;
      sccb_value_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      sccb_start_q <= sccb_start_d;
      sccb_reg_q   <= sccb_reg_d;
      sccb_value_q <= sccb_value_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    sccb_start_d = 1'b0;
    sccb_reg_d   = sccb_reg_q;
    sccb_value_d = sccb_value_q;
    busy_d       = busy_q;
    done_d       = done_q;
    cnt_d        = cnt_q;
    first_d      = first_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d    = S_FETCH1;
          rom_addr_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        if (bus.rom_data == END_WORD) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (bus.rom_data == DELAY_WORD) begin
          state_d = S_DELAY;
          cnt_d   = '0;
        end else begin
          state_d      = S_ISSUE;
          sccb_reg_d   = bus.rom_data[15:8];
          sccb_value_d = bus.rom_data[7:0];
        end
      end
      S_ISSUE: begin
        if (bus.sccb_ready) begin
          state_d      = S_WAIT_SCCB;
          sccb_start_d = 1'b1;
          first_d      = 1'b1;
        end
      end
      S_WAIT_SCCB: begin
        // Master still shows ready on the clock it samples the start pulse
        if (first_q) begin
          first_d = 1'b0;
        end else if (bus.sccb_ready) begin
          state_d = S_NEXT;
        end
      end
      S_DELAY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DELAY_CYCLES - 1)) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (rom_addr_q == {ADDR_W{1'b1}}) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d    = S_FETCH1;
          rom_addr_d = rom_addr_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.sccb_start = sccb_start_q;
  assign bus.sccb_reg   = sccb_reg_q;
  assign bus.sccb_value = sccb_value_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Scoreboard bench for ov7670_config_sequencer: ROM and SCCB behavioural models,
// expected writes derived from the ROM table and checked by an independent monitor.
module tb_ov7670_config_sequencer;

  localparam int unsigned DLY = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ov7670_config_sequencer_if bus();

  ov7670_config_sequencer #(.DELAY_CYCLES(DLY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] rom [256];
  int          lat_min = 2;
  int          lat_max = 2;
  int          sccb_cnt;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [23:0] exp_q[$];
  int          start_cyc[$];
  int          writes_seen = 0;
  logic [7:0]  lat_reg = '0;
  logic [7:0]  lat_val = '0;
  logic        prev_start = 1'b0;
  logic        prev_busy = 1'b0;
  logic [7:0]  prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Config ROM: one-clock registered read
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rom_data <= '0;
    else        bus.rom_data <= rom[bus.rom_addr];
  end

  // SCCB master: drops ready when it takes a start, raises it N clocks later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sccb_ready <= 1'b1;
      sccb_cnt       <= 0;
    end else if (bus.sccb_ready && bus.sccb_start) begin
      bus.sccb_ready <= 1'b0;
      sccb_cnt       <= int'($urandom_range(lat_max, lat_min));
    end else if (!bus.sccb_ready) begin
      if (sccb_cnt <= 1) bus.sccb_ready <= 1'b1;
      else               sccb_cnt <= sccb_cnt - 1;
    end
  end

  // Monitor: pops the scoreboard on every start pulse and polices the bus
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst_n) begin
      if (bus.sccb_start) begin
        check("start_while_ready", 32'(bus.sccb_ready), 32'd1);
        check("start_one_clk", 32'(prev_start), 32'd0);
        writes_seen++;
        start_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h reg %0h val %0h, none expected",
                   bus.rom_addr, bus.sccb_reg, bus.sccb_value);
        end else begin
          e = exp_q.pop_front();
          check("write", 32'({bus.rom_addr, bus.sccb_reg, bus.sccb_value}), 32'(e));
        end
        lat_reg = bus.sccb_reg;
        lat_val = bus.sccb_value;
      end else if (!bus.sccb_ready) begin
        check("hold_reg_value", 32'({bus.sccb_reg, bus.sccb_value}), 32'({lat_reg, lat_val}));
      end
      if (bus.busy && prev_busy && bus.rom_addr != prev_addr)
        check("addr_step", 32'(bus.rom_addr), 32'(prev_addr) + 32'd1);
      prev_start = bus.sccb_start;
      prev_busy  = bus.busy;
      prev_addr  = bus.rom_addr;
    end else begin
      prev_start = 1'b0;
      prev_busy  = 1'b0;
    end
  end

  // Reference model: the writes a table should produce and where the walk stops
  task automatic build_expect(output int end_addr);
    exp_q.delete();
    end_addr = 255;
    for (int a = 0; a < 256; a++) begin
      if (rom[a] == 16'hFFFF) begin
        end_addr = a;
        break;
      end
      if (rom[a] != 16'hFFF0) exp_q.push_back({8'(a), rom[a]});
    end
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_seq(input string name, input int budget, input bit mid_start);
    int end_addr;
    bit fin;
    build_expect(end_addr);
    pulse_start();
    check({name, "_done_drop"}, 32'(bus.done), 32'd0);
    check({name, "_busy_rise"}, 32'(bus.busy), 32'd1);
    fin = 1'b0;
    for (int i = 0; i < budget && !fin; i++) begin
      @(negedge clk);
      bus.start = mid_start && (i == 100);
      if (bus.done) fin = 1'b1;
    end
    bus.start = 1'b0;
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: done still %0b after %0d cycles, required 1", name, bus.done, budget);
    end
    check({name, "_done"}, 32'(bus.done), 32'd1);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_end_addr"}, 32'(bus.rom_addr), 32'(end_addr));
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
    check({name, "_sccb_start"}, 32'(bus.sccb_start), 32'd0);
    check({name, "_sccb_reg"}, 32'(bus.sccb_reg), 32'd0);
    check({name, "_sccb_value"}, 32'(bus.sccb_value), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_done"}, 32'(bus.done), 32'd0);
  endtask

  task automatic reset_mid(input string name);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(name);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_idle_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap_a, gap_b, seen_end, len, r;
    gap_a = 0;
    gap_b = 0;
    bus.start = 1'b0;
    clear_rom();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Delay-entry cost measured against the same table without it
    lat_min = 3; lat_max = 3;
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'h1210;
    start_cyc.delete();
    run_seq("nodelay", 2000, 1'b0);
    if (start_cyc.size() >= 2) gap_a = start_cyc[1] - start_cyc[0];
    clear_rom();
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1210;
    start_cyc.delete();
    run_seq("delay", 2000, 1'b0);
    if (start_cyc.size() >= 2) gap_b = start_cyc[1] - start_cyc[0];
    check("delay_extra_cycles", 32'(gap_b - gap_a), 32'(DLY + 4));

    // Slow SCCB master
    lat_min = 50; lat_max = 50;
    clear_rom();
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333;
    run_seq("slow_sccb", 2000, 1'b0);

    // Full table without end marker, with an ignored mid-run start, then a replay
    lat_min = 1; lat_max = 4;
    for (int a = 0; a < 256; a++) rom[a] = 16'h0101;
    run_seq("full", 20000, 1'b1);
    run_seq("replay", 20000, 1'b0);

    // FFF1 is an ordinary write
    lat_min = 1; lat_max = 3;
    clear_rom();
    rom[0] = 16'hFFF1;
    run_seq("fff1", 2000, 1'b0);

    // Randomised tables
    for (int it = 0; it < 6; it++) begin
      clear_rom();
      len = int'($urandom_range(40, 1));
      for (int a = 0; a < len; a++) begin
        r = int'($urandom_range(9, 0));
        if (r == 0)      rom[a] = 16'hFFF0;
        else if (r == 1) rom[a] = {8'hFF, 8'($urandom)};
        else             rom[a] = 16'($urandom);
      end
      lat_max = int'($urandom_range(6, 1));
      run_seq($sformatf("rand%0d", it), 8000, 1'b0);
    end

    // Reset while waiting in a delay
    clear_rom();
    rom[0] = 16'hFFF0;
    build_expect(seen_end);
    pulse_start();
    repeat (5) @(negedge clk);
    check("pre_rst_delay_busy", 32'(bus.busy), 32'd1);
    reset_mid("rst_delay");

    // Reset while an SCCB write is in flight
    lat_min = 50; lat_max = 50;
    clear_rom();
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h5A3C;
    build_expect(seen_end);
    writes_seen = 0;
    pulse_start();
    for (int i = 0; i < 2000 && writes_seen < 3; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("pre_rst_wait_reg", 32'(bus.sccb_reg), 32'h5A);
    check("pre_rst_wait_ready", 32'(bus.sccb_ready), 32'd0);
    reset_mid("rst_wait");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
